// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory port between the multi-cycle control FSM and memory.
// The controller drives the request strobes and the memory answers with mem_ready.
interface multicycle_control_if;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional MULTICYCLE_PERF_EN adds free-running cycle and retired-instruction counters.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           opcode,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_mode,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic [2:0]           state,
    output logic                 illegal_inst,
    output logic                 mem_timeout,
    output logic                 halted
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instret_count
`endif
);

    // A zero timeout still needs a 1-bit counter to keep the logic well formed.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYS, C_BAD
    } cls_t;

    state_t           st, st_nxt;
    cls_t             dec_cls, cls;
    logic [CNT_W-1:0] wcnt;
    logic             in_mem_wait;
    logic             tmo_hit;
    logic             req_c, rd_c, wr_c, iod_c;

    always_comb begin
        case (opcode)
            OP_R:     dec_cls = C_R;
            OP_I:     dec_cls = C_I;
            OP_LW:    dec_cls = C_LW;
            OP_SW:    dec_cls = C_SW;
            OP_BR:    dec_cls = C_BR;
            OP_JAL:   dec_cls = C_JAL;
            OP_JALR:  dec_cls = C_JALR;
            OP_LUI:   dec_cls = C_LUI;
            OP_AUIPC: dec_cls = C_AUIPC;
            OP_SYS:   dec_cls = C_SYS;
            default:  dec_cls = C_BAD;
        endcase
    end

    assign in_mem_wait = (st == S_FETCH) || (st == S_MEM);
    // mem_ready in the same cycle as the limit wins over the timeout.
    assign tmo_hit     = TMO_EN && in_mem_wait && !mem.mem_ready && (wcnt == TMO_VAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= S_FETCH;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt        = st;
        req_c         = 1'b0;
        rd_c          = 1'b0;
        wr_c          = 1'b0;
        iod_c         = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_mode      = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        case (st)
            S_FETCH: begin
                req_c     = 1'b1;
                rd_c      = 1'b1;
                alu_src_b = 2'b01;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    st_nxt   = S_DECODE;
                end else if (tmo_hit) begin
                    st_nxt = S_ERR;
                end
            end
            S_DECODE: begin
                // Precompute PC+imm so ALUOut holds the branch/JAL target in EXEC.
                alu_src_b = 2'b10;
                case (dec_cls)
                    C_SYS:   st_nxt = S_HALT;
                    C_BAD:   st_nxt = S_ERR;
                    default: st_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                st_nxt = S_WB;
                case (cls)
                    C_R: begin
                        alu_src_a = 2'b01;
                        alu_mode  = 2'b01;
                    end
                    C_I: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        alu_mode  = 2'b01;
                    end
                    C_LW, C_SW: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        st_nxt    = S_MEM;
                    end
                    C_BR: begin
                        alu_src_a     = 2'b01;
                        alu_mode      = 2'b10;
                        pc_write_cond = 1'b1;
                        pc_source     = 2'b01;
                        st_nxt        = S_FETCH;
                    end
                    C_JAL: begin
                        pc_write  = 1'b1;
                        pc_source = 2'b01;
                    end
                    C_JALR: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                    end
                    C_LUI: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b10;
                    end
                    C_AUIPC: begin
                        alu_src_b = 2'b10;
                    end
                    default: st_nxt = S_ERR;
                endcase
            end
            S_MEM: begin
                req_c = 1'b1;
                iod_c = 1'b1;
                rd_c  = (cls == C_LW);
                wr_c  = (cls == C_SW);
                if (mem.mem_ready) begin
                    st_nxt = (cls == C_LW) ? S_WB : S_FETCH;
                end else if (tmo_hit) begin
                    st_nxt = S_ERR;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                case (cls)
                    C_LW:         mem_to_reg = 2'b01;
                    C_JAL, C_JALR: mem_to_reg = 2'b10;
                    default:      mem_to_reg = 2'b00;
                endcase
                st_nxt = S_FETCH;
            end
            default: ;
        endcase
    end

    // Memory strobes are gated by reset so an in-flight access dies immediately.
    assign mem.mem_req   = req_c & reset_n;
    assign mem.mem_read  = rd_c  & reset_n;
    assign mem.mem_write = wr_c  & reset_n;
    assign mem.i_or_d    = iod_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cls <= C_R;
        end else if (st == S_DECODE) begin
            cls <= dec_cls;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt <= '0;
        end else if (st_nxt != st) begin
            wcnt <= '0;
        end else if (in_mem_wait && !mem.mem_ready && (wcnt != '1)) begin
            wcnt <= wcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_inst <= 1'b0;
            mem_timeout  <= 1'b0;
        end else begin
            if ((st == S_DECODE) && (dec_cls == C_BAD)) illegal_inst <= 1'b1;
            if (tmo_hit) mem_timeout <= 1'b1;
        end
    end

    assign halted = (st == S_HALT) || (st == S_ERR);
    assign state  = st;

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (!halted) cycle_count <= cycle_count + 32'd1;
            if ((st_nxt == S_FETCH) && ((st == S_EXEC) || (st == S_MEM) || (st == S_WB)))
                instret_count <= instret_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-state control vectors for each
// instruction class, illegal/SYS halting, handshake timeout and async reset.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] pc_source, alu_src_a, alu_src_b, alu_mode, mem_to_reg;
    logic [2:0] state;
    logic       illegal_inst, mem_timeout, halted;
    int         checks = 0;
    int         errors = 0;

    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .mem           (bus.master),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_mode      (alu_mode),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .state         (state),
        .illegal_inst  (illegal_inst),
        .mem_timeout   (mem_timeout),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // {state, req/read/write/i_or_d, ir_write/pc_write/pc_write_cond, pc_source,
    //  alu_src_a, alu_src_b, alu_mode, mem_to_reg, reg_write, illegal/timeout/halted}
    localparam logic [23:0] F_RDY    = {3'd0, 4'b1100, 3'b110, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] F_WAIT   = {3'd0, 4'b1100, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] DEC      = {3'd1, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_R     = {3'd2, 4'b0000, 3'b000, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_I     = {3'd2, 4'b0000, 3'b000, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_LS    = {3'd2, 4'b0000, 3'b000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_BR    = {3'd2, 4'b0000, 3'b001, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_JAL   = {3'd2, 4'b0000, 3'b010, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_JALR  = {3'd2, 4'b0000, 3'b010, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_LUI   = {3'd2, 4'b0000, 3'b000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] EX_AUIPC = {3'd2, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] MEM_LW   = {3'd3, 4'b1101, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] MEM_SW   = {3'd3, 4'b1011, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [23:0] WB_ALU   = {3'd4, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
    localparam logic [23:0] WB_MDR   = {3'd4, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 3'b000};
    localparam logic [23:0] WB_PC4   = {3'd4, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 3'b000};
    localparam logic [23:0] HALT_V   = {3'd5, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b001};
    localparam logic [23:0] ERR_ILL  = {3'd6, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b101};
    localparam logic [23:0] ERR_TMO  = {3'd6, 4'b0000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b011};

    function automatic logic [23:0] snap();
        return {state, bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d,
                ir_write, pc_write, pc_write_cond, pc_source, alu_src_a, alu_src_b,
                alu_mode, mem_to_reg, reg_write, illegal_inst, mem_timeout, halted};
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] exp [4];
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        opcode = 7'b0100011;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, bus.mem_req, bus.mem_write, illegal_inst, mem_timeout, halted} !== 8'b0) begin
            errors++;
            $display("FAIL reset_hold: got state=%0d req=%b wr=%b ill=%b tmo=%b halt=%b want all 0",
                     state, bus.mem_req, bus.mem_write, illegal_inst, mem_timeout, halted);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (snap() !== F_WAIT) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", snap(), F_WAIT);
        end
        // Walk an SW into MEM with memory stalled, then pull reset mid-access.
        exp = '{F_RDY, DEC, EX_LS, MEM_SW};
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i < 3);
            #1;
            checks++;
            if (snap() !== exp[i]) begin
                errors++;
                $display("FAIL reset_sw_walk step %0d: got %h want %h", i, snap(), exp[i]);
            end
            if (i < 3) adv();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_write, state} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_write: got req=%b wr=%b state=%0d want 0 0 0",
                     bus.mem_req, bus.mem_write, state);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_rtype();
        logic [23:0] exp [5];
        exp = '{F_RDY, DEC, EX_R, WB_ALU, F_RDY};
        opcode = 7'b0110011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (snap() !== exp[i]) begin
                errors++;
                $display("FAIL rtype step %0d: got %h want %h", i, snap(), exp[i]);
            end
            if (i < 4) adv();
        end
    endtask

    task automatic test_lw();
        logic [23:0] exp [9];
        logic        rdy [9];
        exp = '{F_RDY, DEC, EX_LS, MEM_LW, MEM_LW, MEM_LW, MEM_LW, WB_MDR, F_RDY};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            checks++;
            if (snap() !== exp[i]) begin
                errors++;
                $display("FAIL lw_wait step %0d: got %h want %h", i, snap(), exp[i]);
            end
            if (i < 8) adv();
        end
    endtask

    task automatic test_sw();
        logic [23:0] exp [5];
        int          wr_cycles = 0;
        exp = '{F_RDY, DEC, EX_LS, MEM_SW, F_RDY};
        opcode = 7'b0100011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            wr_cycles += int'(bus.mem_write);
            checks++;
            if (snap() !== exp[i]) begin
                errors++;
                $display("FAIL sw step %0d: got %h want %h", i, snap(), exp[i]);
            end
            if (i < 4) adv();
        end
        checks++;
        if (wr_cycles !== 1) begin
            errors++;
            $display("FAIL sw_write_pulse: got %0d cycles want 1", wr_cycles);
        end
    endtask

    task automatic test_branch();
        logic [23:0] exp [4];
        exp = '{F_RDY, DEC, EX_BR, F_RDY};
        opcode = 7'b1100011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (snap() !== exp[i]) begin
                errors++;
                $display("FAIL branch step %0d: got %h want %h", i, snap(), exp[i]);
            end
            if (i < 3) adv();
        end
    endtask

    task automatic test_classes();
        logic [6:0]  ops  [5];
        logic [23:0] exex [5];
        logic [23:0] wbv  [5];
        logic [23:0] exp;
        ops  = '{7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        exex = '{EX_I, EX_JAL, EX_JALR, EX_LUI, EX_AUIPC};
        wbv  = '{WB_ALU, WB_PC4, WB_PC4, WB_ALU, WB_ALU};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                case (i)
                    0:       exp = F_RDY;
                    1:       exp = DEC;
                    2:       exp = exex[k];
                    default: exp = wbv[k];
                endcase
                #1;
                checks++;
                if (snap() !== exp) begin
                    errors++;
                    $display("FAIL class op=%b step %0d: got %h want %h", ops[k], i, snap(), exp);
                end
                adv();
            end
        end
    endtask

    task automatic test_halt();
        opcode = 7'b1110011;
        bus.mem_ready = 1'b1;
        adv();
        adv();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (snap() !== HALT_V) begin
                errors++;
                $display("FAIL sys_halt cycle %0d: got %h want %h", i, snap(), HALT_V);
            end
            adv();
        end
        do_reset();
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (snap() !== F_RDY) begin
            errors++;
            $display("FAIL illegal_fetch: got %h want %h", snap(), F_RDY);
        end
        adv();
        checks++;
        if (snap() !== DEC) begin
            errors++;
            $display("FAIL illegal_decode: got %h want %h", snap(), DEC);
        end
        adv();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (snap() !== ERR_ILL) begin
                errors++;
                $display("FAIL illegal_err cycle %0d: got %h want %h", i, snap(), ERR_ILL);
            end
            adv();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({state, illegal_inst, halted} !== 5'b0) begin
            errors++;
            $display("FAIL illegal_clear: got state=%0d ill=%b halt=%b want 0 0 0",
                     state, illegal_inst, halted);
        end
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (snap() !== F_WAIT) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: got %h want %h", i, snap(), F_WAIT);
            end
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (snap() !== ERR_TMO) begin
                errors++;
                $display("FAIL timeout_err cycle %0d: got %h want %h", i, snap(), ERR_TMO);
            end
            adv();
        end
        // Ready arriving on the last allowed cycle must complete normally.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = (i == 4);
            #1;
            checks++;
            if (snap() !== ((i == 4) ? F_RDY : F_WAIT)) begin
                errors++;
                $display("FAIL timeout_edge cycle %0d: got %h want %h", i, snap(),
                         (i == 4) ? F_RDY : F_WAIT);
            end
            adv();
        end
        checks++;
        if (snap() !== DEC) begin
            errors++;
            $display("FAIL timeout_edge_decode: got %h want %h", snap(), DEC);
        end
        do_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        opcode = 7'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_branch();
        test_classes();
        test_halt();
        test_illegal();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder: FSM that sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over several cycles.
- Shares one memory port between instruction and data via a req/ready handshake with a bounded wait.
- Sits between the instruction register and the multi-cycle datapath.
- Flags illegal opcodes and memory timeouts with a sticky error state.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent waiting for mem_ready in one access before error; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): wait-counter width (derived, never overridden).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register (valid from DECODE onward)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request active
- mem_read  out  1  read request
- mem_write  out  1  write request
- i_or_d  out  1  0 = PC address, 1 = ALU-result address
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if the branch compare is true
- pc_source  out  2  00 ALU (PC+4), 01 ALUOut (target), 10 ALU (JALR, LSB cleared)
- alu_src_a  out  2  00 PC, 01 rs1, 10 zero
- alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate
- alu_mode  out  2  00 add, 01 funct-decoded, 10 branch compare
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC+4
- reg_write  out  1  register-file write enable
- state  out  3  current state, for debug
- illegal_inst  out  1  sticky: unsupported opcode
- mem_timeout  out  1  sticky: handshake timeout
- halted  out  1  HALT or ERR reached

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- Reset (async, reset_n low):
  - state=FETCH; wait counter=0; illegal_inst=mem_timeout=halted=0.
  - Outputs then take FETCH decode with mem_ready low: mem_req=1, mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_mode=00, pc_source=00; all other outputs 0.
- Outputs are combinational from state, latched opcode class and mem_ready. The opcode class is latched at the end of DECODE and held through WB.
- FETCH:
  - Assert mem_req and mem_read; ALU computes PC+4.
  - Hold until mem_ready.
  - In the ready cycle: ir_write=1, pc_write=1, then go to DECODE.
- DECODE:
  - alu_src_a=00, alu_src_b=10, alu_mode=00, so ALUOut holds the branch/JAL target.
  - Latch the class and go to EXEC.
  - Classes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYS 1110011.
  - SYS goes to HALT. Any other opcode goes to ERR and sets illegal_inst.
- EXEC (one cycle):
  - R: src_a=01, src_b=00, mode=01 → WB.
  - I: src_a=01, src_b=10, mode=01 → WB.
  - LW/SW: src_a=01, src_b=10, mode=00 → MEM.
  - BR: src_a=01, src_b=00, mode=10, pc_write_cond=1, pc_source=01 → FETCH.
  - JAL: pc_write=1, pc_source=01 → WB.
  - JALR: src_a=01, src_b=10, mode=00, pc_write=1, pc_source=10 → WB.
  - LUI: src_a=10, src_b=10 → WB.
  - AUIPC: src_a=00, src_b=10 → WB. The datapath supplies the old PC latched at FETCH.
- MEM:
  - mem_req=1, i_or_d=1; mem_read=1 for LW, mem_write=1 for SW.
  - Hold until mem_ready; then LW → WB, SW → FETCH.
  - mem_write stays asserted for the whole wait and drops the cycle after ready.
- WB (one cycle):
  - reg_write=1, then go to FETCH.
  - mem_to_reg: LW=01, JAL/JALR=10, others=00.
- HALT and ERR:
  - Terminal; every strobe is 0 and halted=1.
  - Only reset exits.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle mem_ready is low.
  - If the counter equals TIMEOUT_CYCLES and mem_ready is still low (TIMEOUT_CYCLES≠0), go to ERR, set mem_timeout, drop mem_req next cycle.
  - mem_ready in that same cycle wins: normal completion, no timeout.
  - The counter saturates; it never wraps.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-access drops mem_req asynchronously; no partial write strobe survives reset.
- CPI: R/I/LUI/AUIPC/JAL/JALR = 4, BR = 3, SW = 4, LW = 5, each plus memory wait cycles.

Optional Feature:
- MULTICYCLE_PERF_EN defined:
  - Adds outputs cycle_count (32) and instret_count (32), both reset to 0.
  - cycle_count increments every cycle while not halted.
  - instret_count increments on each transition into FETCH from EXEC/MEM/WB.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- R-type 0110011, mem_ready held high → states 0,1,2,4,0; reg_write=1 only in WB; 4 cycles per instruction.
- LW with mem_ready delayed 3 cycles in MEM → MEM held 4 cycles with mem_read=1, i_or_d=1; then WB with mem_to_reg=01.
- SW with no wait → mem_write=1 for exactly one cycle; SW→FETCH without WB; reg_write never asserted.
- BR → pc_write_cond=1, pc_source=01 in EXEC; back to FETCH after 3 cycles.
- Opcode 1111111 → ERR after DECODE; illegal_inst=1 and halted=1 held for 20 cycles; reset_n low clears both.
- TIMEOUT_CYCLES=4, mem_ready never asserted in FETCH → ERR entered 5 cycles after reset release; mem_timeout=1 and mem_req=0 afterwards. Repeat with mem_ready on cycle 5 → normal DECODE.
